// File: rtl/datapath_seq.sv
// Sequenced W-bit datapath: register file, A/B/C pipeline registers, shifter, ALU and Z/N/V flags.
// A single start strobe runs a full read/execute/writeback command (or an immediate move) to completion.
module datapath_seq #(
  parameter int W     = 16,
  parameter int NREGS = 8,
  localparam int AW   = (NREGS > 1) ? $clog2(NREGS) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          cmd_movi,
  input  logic [AW-1:0] cmd_rd,
  input  logic [AW-1:0] cmd_rn,
  input  logic [AW-1:0] cmd_rm,
  input  logic [1:0]    cmd_aluop,
  input  logic [1:0]    cmd_shift,
  input  logic          cmd_asel,
  input  logic          cmd_bsel,
  input  logic          cmd_wb,
  input  logic [W-1:0]  cmd_imm,
  output logic          busy,
  output logic          done,
  output logic [W-1:0]  datapath_out,
  output logic          Z_out,
  output logic          N_out,
  output logic          V_out,
  input  logic [AW-1:0] dbg_num,
  output logic [W-1:0]  dbg_data
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD_A = 3'd1,
    S_LOAD_B = 3'd2,
    S_EXEC   = 3'd3,
    S_WB     = 3'd4,
    S_WIMM   = 3'd5
  } state_t;

  state_t        r_state;
  logic          r_busy;
  logic          r_done;
  logic [W-1:0]  r_regs [NREGS];
  logic [W-1:0]  r_a;
  logic [W-1:0]  r_b;
  logic [W-1:0]  r_c;
  logic          r_z;
  logic          r_n;
  logic          r_v;

  // Command fields captured at accept so the caller may change inputs mid-command
  logic [AW-1:0] r_rd;
  logic [AW-1:0] r_rn;
  logic [AW-1:0] r_rm;
  logic [1:0]    r_aluop;
  logic [1:0]    r_shift;
  logic          r_asel;
  logic          r_bsel;
  logic          r_wb;
  logic [W-1:0]  r_imm;

  logic [W-1:0]  w_shifted;
  logic [W-1:0]  w_ain;
  logic [W-1:0]  w_bin;
  logic [W-1:0]  w_result;
  logic          w_v;

  always_comb begin
    w_shifted = r_b;
    case (r_shift)
      2'b01:   w_shifted = {r_b[W-2:0], 1'b0};
      2'b10:   w_shifted = {1'b0, r_b[W-1:1]};
      2'b11:   w_shifted = {r_b[W-1], r_b[W-1:1]};
      default: w_shifted = r_b;
    endcase
  end

  assign w_ain = r_asel ? '0 : r_a;
  assign w_bin = r_bsel ? r_imm : w_shifted;

  always_comb begin
    w_result = '0;
    w_v      = 1'b0;
    case (r_aluop)
      2'b00: begin
        w_result = w_ain + w_bin;
        w_v      = (w_ain[W-1] == w_bin[W-1]) && (w_result[W-1] != w_ain[W-1]);
      end
      2'b01: begin
        w_result = w_ain - w_bin;
        w_v      = (w_ain[W-1] != w_bin[W-1]) && (w_result[W-1] != w_ain[W-1]);
      end
      2'b10:   w_result = w_ain & w_bin;
      default: w_result = ~w_bin;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_a     <= '0;
      r_b     <= '0;
      r_c     <= '0;
      r_z     <= 1'b0;
      r_n     <= 1'b0;
      r_v     <= 1'b0;
      r_rd    <= '0;
      r_rn    <= '0;
      r_rm    <= '0;
      r_aluop <= '0;
      r_shift <= '0;
      r_asel  <= 1'b0;
      r_bsel  <= 1'b0;
      r_wb    <= 1'b0;
      r_imm   <= '0;
      for (int i = 0; i < NREGS; i++) begin
        r_regs[i] <= '0;
      end
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_rd    <= cmd_rd;
            r_rn    <= cmd_rn;
            r_rm    <= cmd_rm;
            r_aluop <= cmd_aluop;
            r_shift <= cmd_shift;
            r_asel  <= cmd_asel;
            r_bsel  <= cmd_bsel;
            r_wb    <= cmd_wb;
            r_imm   <= cmd_imm;
            r_busy  <= 1'b1;
            if (cmd_movi) begin
              r_state <= S_WIMM;
              r_done  <= 1'b1;
            end else begin
              r_state <= S_LOAD_A;
            end
          end
        end
        S_LOAD_A: begin
          r_a     <= r_regs[r_rn];
          r_state <= S_LOAD_B;
        end
        S_LOAD_B: begin
          r_b     <= r_regs[r_rm];
          r_state <= S_EXEC;
        end
        S_EXEC: begin
          r_c     <= w_result;
          r_z     <= (w_result == '0);
          r_n     <= w_result[W-1];
          r_v     <= w_v;
          r_done  <= 1'b1;
          r_state <= S_WB;
        end
        S_WB: begin
          if (r_wb) begin
            r_regs[r_rd] <= r_c;
          end
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        S_WIMM: begin
          r_regs[r_rd] <= r_imm;
          r_done       <= 1'b0;
          r_busy       <= 1'b0;
          r_state      <= S_IDLE;
        end
        default: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign busy         = r_busy;
  assign done         = r_done;
  assign datapath_out = r_c;
  assign Z_out        = r_z;
  assign N_out        = r_n;
  assign V_out        = r_v;
  assign dbg_data     = r_regs[dbg_num];

endmodule

// File: tb/tb_datapath_seq.sv
// Directed-vector bench for datapath_seq: a W=16/NREGS=8 instance driven from a command table
// plus back-to-back, mid-command reset and a W=8/NREGS=4 instance.
module tb_datapath_seq;

  logic clk;
  logic reset;

  logic        start16, movi16, asel16, bsel16, wb16;
  logic [2:0]  rd16, rn16, rm16, dbgn16;
  logic [1:0]  op16, sh16;
  logic [15:0] imm16, c16, dbgd16;
  logic        busy16, done16, z16, n16, v16;

  logic        start8, movi8, asel8, bsel8, wb8;
  logic [1:0]  rd8, rn8, rm8, dbgn8;
  logic [1:0]  op8, sh8;
  logic [7:0]  imm8, c8, dbgd8;
  logic        busy8, done8, z8, n8, v8;

  int n_checks = 0;
  int n_err    = 0;
  logic [15:0] model [8];

  datapath_seq #(.W(16), .NREGS(8)) dut16 (
    .clk(clk), .reset(reset), .start(start16), .cmd_movi(movi16),
    .cmd_rd(rd16), .cmd_rn(rn16), .cmd_rm(rm16), .cmd_aluop(op16), .cmd_shift(sh16),
    .cmd_asel(asel16), .cmd_bsel(bsel16), .cmd_wb(wb16), .cmd_imm(imm16),
    .busy(busy16), .done(done16), .datapath_out(c16),
    .Z_out(z16), .N_out(n16), .V_out(v16), .dbg_num(dbgn16), .dbg_data(dbgd16)
  );

  datapath_seq #(.W(8), .NREGS(4)) dut8 (
    .clk(clk), .reset(reset), .start(start8), .cmd_movi(movi8),
    .cmd_rd(rd8), .cmd_rn(rn8), .cmd_rm(rm8), .cmd_aluop(op8), .cmd_shift(sh8),
    .cmd_asel(asel8), .cmd_bsel(bsel8), .cmd_wb(wb8), .cmd_imm(imm8),
    .busy(busy8), .done(done8), .datapath_out(c8),
    .Z_out(z8), .N_out(n8), .V_out(v8), .dbg_num(dbgn8), .dbg_data(dbgd8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        movi;
    logic [2:0]  rd, rn, rm;
    logic [1:0]  op, sh;
    logic        asel, bsel, wb;
    logic [15:0] imm;
    logic [15:0] exp_c;
    logic        exp_z, exp_n, exp_v;
    logic [15:0] exp_rd;
  } vec_t;

  vec_t vecs [14];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_regs16(input string tag);
    for (int i = 0; i < 8; i++) begin
      dbgn16 = 3'(i);
      #1;
      chk($sformatf("%s R%0d", tag, i), dbgd16, model[i]);
    end
  endtask

  task automatic chk_flags16(input string tag, input logic [15:0] c, input logic z, input logic n, input logic v);
    chk({tag, " C"}, c16, c);
    chk({tag, " ZNV"}, {13'd0, z16, n16, v16}, {13'd0, z, n, v});
  endtask

  task automatic drive16(input vec_t v);
    movi16 = v.movi; rd16 = v.rd; rn16 = v.rn; rm16 = v.rm;
    op16 = v.op; sh16 = v.sh; asel16 = v.asel; bsel16 = v.bsel;
    wb16 = v.wb; imm16 = v.imm;
  endtask

  task automatic run16(input int idx, input vec_t v);
    int busy_cnt, done_cnt, cyc;
    logic [15:0] c_at_done;
    busy_cnt = 0; done_cnt = 0; cyc = 0; c_at_done = 16'hxxxx;
    @(negedge clk);
    drive16(v);
    start16 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start16 = 1'b0;
    drive16('{1'b0, 3'd7, 3'd7, 3'd7, 2'b11, 2'b11, 1'b1, 1'b1, 1'b0, 16'hDEAD,
              16'h0, 1'b0, 1'b0, 1'b0, 16'h0});
    while (busy16 && cyc < 20) begin
      busy_cnt++;
      if (done16) begin
        done_cnt++;
        c_at_done = c16;
      end
      @(negedge clk);
      cyc++;
    end
    $display("cmd %0d: movi=%0b rd=%0d rn=%0d rm=%0d op=%0d sh=%0d C=%h ZNV=%0b%0b%0b busy_cycles=%0d",
             idx, v.movi, v.rd, v.rn, v.rm, v.op, v.sh, c16, z16, n16, v16, busy_cnt);
    chk($sformatf("cmd%0d busy cycles", idx), 16'(busy_cnt), v.movi ? 16'd1 : 16'd4);
    chk($sformatf("cmd%0d done cycles", idx), 16'(done_cnt), 16'd1);
    chk($sformatf("cmd%0d C at done", idx), c_at_done, v.exp_c);
    chk_flags16($sformatf("cmd%0d", idx), v.exp_c, v.exp_z, v.exp_n, v.exp_v);
    if (v.movi || v.wb) model[v.rd] = v.exp_rd;
    chk_regs16($sformatf("cmd%0d", idx));
  endtask

  task automatic run8(input int idx, input logic movi, input logic [1:0] rd, input logic [1:0] rn,
                      input logic [1:0] rm, input logic [1:0] sh, input logic asel, input logic bsel,
                      input logic [7:0] imm, input logic [7:0] exp_c, input logic [2:0] exp_znv,
                      input logic [7:0] exp_rd);
    int cyc;
    cyc = 0;
    @(negedge clk);
    movi8 = movi; rd8 = rd; rn8 = rn; rm8 = rm; op8 = 2'b00; sh8 = sh;
    asel8 = asel; bsel8 = bsel; wb8 = 1'b1; imm8 = imm; start8 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start8 = 1'b0;
    while (busy8 && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    dbgn8 = rd;
    #1;
    $display("w8 cmd %0d: rd=%0d C=%h ZNV=%0b%0b%0b R[rd]=%h", idx, rd, c8, z8, n8, v8, dbgd8);
    chk($sformatf("w8 cmd%0d busy ends", idx), 16'(cyc < 20), 16'd1);
    chk($sformatf("w8 cmd%0d C", idx), {8'd0, c8}, {8'd0, exp_c});
    chk($sformatf("w8 cmd%0d ZNV", idx), {13'd0, z8, n8, v8}, {13'd0, exp_znv});
    chk($sformatf("w8 cmd%0d R[rd]", idx), {8'd0, dbgd8}, {8'd0, exp_rd});
  endtask

  initial begin
    int k, d1, d2, d3, ndone;
    //         movi  rd    rn    rm    op     sh     asel  bsel  wb    imm       exp_c     z     n     v     exp_rd
    vecs[0]  = '{1'b1, 3'd0, 3'd0, 3'd0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 16'h0007, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0007};
    vecs[1]  = '{1'b1, 3'd1, 3'd0, 3'd0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 16'h0002, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0002};
    vecs[2]  = '{1'b0, 3'd2, 3'd1, 3'd0, 2'b00, 2'b01, 1'b0, 1'b0, 1'b1, 16'h0000, 16'h0010, 1'b0, 1'b0, 1'b0, 16'h0010};
    vecs[3]  = '{1'b0, 3'd6, 3'd0, 3'd0, 2'b01, 2'b00, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0000};
    vecs[4]  = '{1'b1, 3'd3, 3'd0, 3'd0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 16'h7FFF, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h7FFF};
    vecs[5]  = '{1'b1, 3'd4, 3'd0, 3'd0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 16'hFFFF, 16'h0000, 1'b1, 1'b0, 1'b0, 16'hFFFF};
    vecs[6]  = '{1'b0, 3'd5, 3'd3, 3'd4, 2'b01, 2'b00, 1'b0, 1'b0, 1'b1, 16'h0000, 16'h8000, 1'b0, 1'b1, 1'b1, 16'h8000};
    vecs[7]  = '{1'b0, 3'd6, 3'd4, 3'd3, 2'b10, 2'b10, 1'b0, 1'b0, 1'b1, 16'h0000, 16'h3FFF, 1'b0, 1'b0, 1'b0, 16'h3FFF};
    vecs[8]  = '{1'b0, 3'd7, 3'd0, 3'd4, 2'b11, 2'b00, 1'b0, 1'b1, 1'b1, 16'h00F0, 16'hFF0F, 1'b0, 1'b1, 1'b0, 16'hFF0F};
    vecs[9]  = '{1'b0, 3'd3, 3'd3, 3'd3, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1, 16'h0000, 16'hFFFE, 1'b0, 1'b1, 1'b1, 16'hFFFE};
    vecs[10] = '{1'b0, 3'd0, 3'd0, 3'd1, 2'b01, 2'b01, 1'b0, 1'b0, 1'b1, 16'h0000, 16'h0003, 1'b0, 1'b0, 1'b0, 16'h0003};
    vecs[11] = '{1'b0, 3'd1, 3'd5, 3'd5, 2'b00, 2'b11, 1'b1, 1'b0, 1'b1, 16'h0000, 16'hC000, 1'b0, 1'b1, 1'b0, 16'hC000};
    vecs[12] = '{1'b1, 3'd2, 3'd0, 3'd0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 16'h0005, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0005};
    vecs[13] = '{1'b0, 3'd3, 3'd2, 3'd2, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1, 16'h0000, 16'h000A, 1'b0, 1'b0, 1'b0, 16'h000A};

    for (int i = 0; i < 8; i++) model[i] = 16'h0;
    reset = 1'b1;
    start16 = 1'b0; dbgn16 = 3'd0;
    drive16(vecs[0]);
    start8 = 1'b0; movi8 = 1'b0; rd8 = 2'd0; rn8 = 2'd0; rm8 = 2'd0; op8 = 2'b00; sh8 = 2'b00;
    asel8 = 1'b0; bsel8 = 1'b0; wb8 = 1'b0; imm8 = 8'h00; dbgn8 = 2'd0;
    repeat (2) @(negedge clk);
    reset = 1'b0;

    chk("reset busy/done", {14'd0, busy16, done16}, 16'd0);
    chk_flags16("reset", 16'h0000, 1'b0, 1'b0, 1'b0);
    chk_regs16("reset");

    for (int i = 0; i < 12; i++) run16(i, vecs[i]);

    // Back-to-back: start held high from IDLE; deassert after the third accept
    @(negedge clk);
    drive16('{1'b0, 3'd7, 3'd1, 3'd1, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1, 16'h0000,
              16'h8000, 1'b0, 1'b1, 1'b0, 16'h8000});
    start16 = 1'b1;
    ndone = 0; d1 = 0; d2 = 0; d3 = 0;
    for (k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (k == 12) start16 = 1'b0;
      if (done16) begin
        ndone++;
        if (ndone == 1) d1 = k;
        else if (ndone == 2) d2 = k;
        else if (ndone == 3) d3 = k;
      end
    end
    $display("b2b: done pulses=%0d at cycles %0d %0d %0d", ndone, d1, d2, d3);
    chk("b2b done count", 16'(ndone), 16'd3);
    chk("b2b spacing 1-2", 16'(d2 - d1), 16'd5);
    chk("b2b spacing 2-3", 16'(d3 - d2), 16'd5);
    chk("b2b idle at end", {15'd0, busy16}, 16'd0);
    chk_flags16("b2b", 16'h8000, 1'b0, 1'b1, 1'b0);
    model[7] = 16'h8000;
    chk_regs16("b2b");

    // Asynchronous reset asserted between edges while in EXEC
    @(negedge clk);
    drive16('{1'b0, 3'd0, 3'd1, 3'd1, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1, 16'h0000,
              16'h0, 1'b0, 1'b0, 1'b0, 16'h0});
    start16 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start16 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("pre-reset in EXEC busy", {15'd0, busy16}, 16'd1);
    #2 reset = 1'b1;
    #1;
    $display("async reset mid-EXEC: busy=%0b done=%0b C=%h", busy16, done16, c16);
    chk("async reset busy/done", {14'd0, busy16, done16}, 16'd0);
    chk_flags16("async reset", 16'h0000, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) model[i] = 16'h0;
    chk_regs16("async reset");
    @(negedge clk);
    reset = 1'b0;
    chk("after reset no wb R0", dbgd16, 16'h0000);
    run16(12, vecs[12]);
    run16(13, vecs[13]);

    // W=8, NREGS=4 instance
    run8(0, 1'b1, 2'd0, 2'd0, 2'd0, 2'b00, 1'b0, 1'b0, 8'h7F, 8'h00, 3'b000, 8'h7F);
    run8(1, 1'b0, 2'd1, 2'd0, 2'd0, 2'b00, 1'b0, 1'b1, 8'h01, 8'h80, 3'b011, 8'h80);
    run8(2, 1'b0, 2'd2, 2'd0, 2'd1, 2'b11, 1'b1, 1'b0, 8'h00, 8'hC0, 3'b010, 8'hC0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
